// File: rtl/lcb_unpacker.sv
// lcb_unpacker: unpacks packed-sample byte groups (one header byte carrying the
// high bits of every channel, then one low byte per channel) into word-RAM
// writes, with word addresses looked up in an external address ROM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an rxValid rising episode to accept a byte
// WRITE    | one-cycle word-RAM write; ROM counter advances
// WAIT_LOW | byte consumed, waiting for rxValid to drop
module lcb_unpacker #(
    parameter int NCH       = 4,
    parameter int GROUPS    = 3,
    parameter int ROM_DEPTH = 384,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 15,
    parameter int WADDR_LSB = 4,
    parameter int WADDR_W   = 10,
    parameter int OUT_W     = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rawData,
    input  logic               rxValid,
    input  logic               frameSync,
    output logic [ADDR_W-1:0]  addrROMaddr,
    input  logic [DATA_W-1:0]  dataROMaddr,
    output logic [OUT_W-1:0]   wrdOut,
    output logic [WADDR_W-1:0] wrdAddr,
    output logic               wren,
    output logic               frameDone,
    output logic               test
);

    localparam int HB = 8 / NCH;
    localparam int SW = 8 + HB;
    localparam int PW = $clog2(NCH + 1);
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t state_q, state_d;

    // The byte counter is held as (group, position-in-group) so the header
    // test needs no modulo by NCH+1.
    logic [PW-1:0]     pos_q;
    logic [GW-1:0]     grp_q;
    logic [ADDR_W-1:0] rc_q;
    logic [HB-1:0]     hi_q [NCH];
    logic              armed_q;
    logic              accept;
    logic [HB-1:0]     hi_sel;
    logic [DATA_W-1:0] unused_rom;

    // Only the word-address field of the ROM data matters.
    assign unused_rom = dataROMaddr;

    // A byte is taken once per rxValid episode, and never on a realign cycle.
    assign accept = (state_q == IDLE) && rxValid && armed_q && !frameSync;

    assign addrROMaddr = rc_q;
    assign test        = (grp_q == GW'(GROUPS - 1));

    // High part of the channel addressed by the current low byte.
    always_comb begin
        hi_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pos_q == PW'(i + 1)) begin
                hi_sel = hi_q[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (frameSync) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = (pos_q == '0) ? WAIT_LOW : WRITE;
                    end
                end
                WRITE:    state_d = WAIT_LOW;
                WAIT_LOW: begin
                    if (!rxValid) begin
                        state_d = IDLE;
                    end
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    // Counters, channel registers and the registered write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q     <= '0;
            grp_q     <= '0;
            rc_q      <= '0;
            wrdOut    <= '0;
            wrdAddr   <= '0;
            wren      <= 1'b0;
            frameDone <= 1'b0;
            armed_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                hi_q[i] <= '0;
            end
        end else begin
            // armed drops on acceptance and re-arms only after rxValid is seen low,
            // which also ignores a level already high when reset is released.
            if (!rxValid) begin
                armed_q <= 1'b1;
            end else if (accept) begin
                armed_q <= 1'b0;
            end

            wren      <= 1'b0;
            frameDone <= 1'b0;

            if (frameSync) begin
                pos_q <= '0;
                grp_q <= '0;
                rc_q  <= '0;
            end else begin
                if (accept) begin
                    if (pos_q == PW'(NCH)) begin
                        pos_q <= '0;
                        grp_q <= (grp_q == GW'(GROUPS - 1)) ? '0 : grp_q + GW'(1);
                    end else begin
                        pos_q <= pos_q + PW'(1);
                    end

                    if (pos_q == '0) begin
                        for (int i = 0; i < NCH; i++) begin
                            hi_q[i] <= rawData[7 - i*HB -: HB];
                        end
                    end else begin
                        wrdOut    <= OUT_W'({hi_sel, rawData, 1'b0});
                        wrdAddr   <= dataROMaddr[WADDR_LSB +: WADDR_W];
                        wren      <= 1'b1;
                        frameDone <= (rc_q == ADDR_W'(ROM_DEPTH - 1));
                    end
                end

                if (state_q == WRITE) begin
                    rc_q <= (rc_q == ADDR_W'(ROM_DEPTH - 1)) ? '0 : rc_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lcb_unpacker.sv
// Directed bench for lcb_unpacker: default configuration plus an NCH=2 instance.
module tb_lcb_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  rawData;
    logic        rxValid;
    logic        frameSync;
    logic [8:0]  addrROMaddr;
    logic [14:0] dataROMaddr;
    logic [11:0] wrdOut;
    logic [9:0]  wrdAddr;
    logic        wren, frameDone, test;

    logic [7:0]  rawData2;
    logic        rxValid2;
    logic        frameSync2;
    logic [8:0]  addrROMaddr2;
    logic [14:0] dataROMaddr2;
    logic [13:0] wrdOut2;
    logic [9:0]  wrdAddr2;
    logic        wren2, frameDone2, test2;

    lcb_unpacker dut (
        .clk(clk), .reset(reset), .rawData(rawData), .rxValid(rxValid),
        .frameSync(frameSync), .addrROMaddr(addrROMaddr), .dataROMaddr(dataROMaddr),
        .wrdOut(wrdOut), .wrdAddr(wrdAddr), .wren(wren), .frameDone(frameDone),
        .test(test)
    );

    lcb_unpacker #(.NCH(2), .OUT_W(14)) dut2 (
        .clk(clk), .reset(reset), .rawData(rawData2), .rxValid(rxValid2),
        .frameSync(frameSync2), .addrROMaddr(addrROMaddr2), .dataROMaddr(dataROMaddr2),
        .wrdOut(wrdOut2), .wrdAddr(wrdAddr2), .wren(wren2), .frameDone(frameDone2),
        .test(test2)
    );

    // Address ROM model: word address = ROM address + 100, with junk around it.
    always @(posedge clk) begin
        dataROMaddr  <= {1'b1, 10'(10'(addrROMaddr) + 10'd100), 4'hF};
        dataROMaddr2 <= {1'b1, 10'(10'(addrROMaddr2) + 10'd100), 4'hF};
    end

    int checks = 0;
    int errors = 0;

    int wren_cnt = 0, fd_cnt = 0, fd_at = 0, fd_stray = 0, dbl = 0;
    logic prev_wren = 1'b0;
    always @(negedge clk) begin
        if (wren) begin
            wren_cnt++;
            if (frameDone) begin
                fd_cnt++;
                fd_at = wren_cnt;
            end
        end else if (frameDone) begin
            fd_stray++;
        end
        if (wren && prev_wren) dbl++;
        prev_wren = wren;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic hold_valid);
        reset     = 1'b0;
        rxValid   = hold_valid;
        rawData   = 8'h00;
        frameSync = 1'b0;
        rxValid2  = 1'b0;
        rawData2  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_fdone", 32'(frameDone), 32'd0);
        chk("rst_wrdOut", 32'(wrdOut), 32'd0);
        chk("rst_wrdAddr", 32'(wrdAddr), 32'd0);
        chk("rst_romaddr", 32'(addrROMaddr), 32'd0);
        chk("rst_test", 32'(test), 32'd0);
        reset = 1'b1;
    endtask

    // One byte episode: one cycle high, then low long enough to return to IDLE.
    task automatic send(input logic [7:0] b, output logic w, output logic w_next,
                        output logic [11:0] wo, output logic [9:0] wa, output logic t);
        @(posedge clk); #1;
        rawData = b;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
        w  = wren;
        wo = wrdOut;
        wa = wrdAddr;
        t  = test;
        @(posedge clk); #1;
        w_next = wren;
        repeat (2) @(posedge clk);
    endtask

    task automatic send2(input logic [7:0] b, output logic w, output logic [13:0] wo);
        @(posedge clk); #1;
        rawData2 = b;
        rxValid2 = 1'b1;
        @(posedge clk); #1;
        rxValid2 = 1'b0;
        w  = wren2;
        wo = wrdOut2;
        repeat (3) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        exp_wren;
        logic [11:0] exp_wrd;
        logic        exp_test;
    } vec_t;

    vec_t vecs[16];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic w, wn, t;
        logic [11:0] wo;
        logic [9:0] wa;
        logic [13:0] wo2;
        int j, base_w, base_fd;

        vecs[0]  = '{8'hE4, 1'b0, 12'h000, 1'b0};
        vecs[1]  = '{8'h12, 1'b1, 12'h624, 1'b0};
        vecs[2]  = '{8'h34, 1'b1, 12'h468, 1'b0};
        vecs[3]  = '{8'h56, 1'b1, 12'h2AC, 1'b0};
        vecs[4]  = '{8'h78, 1'b1, 12'h0F0, 1'b0};
        vecs[5]  = '{8'h1B, 1'b0, 12'h000, 1'b0};
        vecs[6]  = '{8'hFF, 1'b1, 12'h1FE, 1'b0};
        vecs[7]  = '{8'h00, 1'b1, 12'h200, 1'b0};
        vecs[8]  = '{8'h80, 1'b1, 12'h500, 1'b0};
        vecs[9]  = '{8'h01, 1'b1, 12'h602, 1'b1};
        vecs[10] = '{8'hC0, 1'b0, 12'h000, 1'b1};
        vecs[11] = '{8'h01, 1'b1, 12'h602, 1'b1};
        vecs[12] = '{8'h02, 1'b1, 12'h004, 1'b1};
        vecs[13] = '{8'h03, 1'b1, 12'h006, 1'b1};
        vecs[14] = '{8'h04, 1'b1, 12'h008, 1'b0};
        vecs[15] = '{8'h40, 1'b0, 12'h000, 1'b0};

        // Table-driven full frame plus the first header of the next frame.
        do_reset(1'b0);
        j = 0;
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].data, w, wn, wo, wa, t);
            chk($sformatf("v%0d_wren", i), 32'(w), 32'(vecs[i].exp_wren));
            chk($sformatf("v%0d_wren_next", i), 32'(wn), 32'd0);
            chk($sformatf("v%0d_test", i), 32'(t), 32'(vecs[i].exp_test));
            if (vecs[i].exp_wren) begin
                chk($sformatf("v%0d_wrdOut", i), 32'(wo), 32'(vecs[i].exp_wrd));
                chk($sformatf("v%0d_wrdAddr", i), 32'(wa), 32'(10'(j + 100)));
                j++;
            end
            if (i == 4) chk("rc_after_group0", 32'(addrROMaddr), 32'd4);
        end
        chk("rc_after_frame", 32'(addrROMaddr), 32'd12);

        // Level already high at reset release is ignored; held-high gives one write.
        do_reset(1'b1);
        repeat (5) @(posedge clk);
        #1 rxValid = 1'b0;
        repeat (2) @(posedge clk);
        send(8'hFF, w, wn, wo, wa, t);
        chk("held_rel_hdr_wren", 32'(w), 32'd0);
        send(8'h11, w, wn, wo, wa, t);
        chk("held_rel_low_wren", 32'(w), 32'd1);
        chk("held_rel_low_wrd", 32'(wo), 32'h622);
        base_w = wren_cnt;
        @(posedge clk); #1;
        rawData = 8'h22;
        rxValid = 1'b1;
        repeat (10) @(posedge clk);
        #1 rxValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held10_pulses", 32'(wren_cnt - base_w), 32'd1);
        chk("held10_wrd", 32'(wrdOut), 32'h644);
        send(8'h33, w, wn, wo, wa, t);
        chk("after_low_wren", 32'(w), 32'd1);
        chk("after_low_wrd", 32'(wo), 32'h666);

        // frameSync after header + 2 low bytes realigns to a header.
        do_reset(1'b0);
        send(8'hFF, w, wn, wo, wa, t);
        send(8'h01, w, wn, wo, wa, t);
        send(8'h02, w, wn, wo, wa, t);
        chk("fs_rc_before", 32'(addrROMaddr), 32'd2);
        base_w = wren_cnt;
        @(posedge clk); #1 frameSync = 1'b1;
        @(posedge clk); #1 frameSync = 1'b0;
        chk("fs_rc_after", 32'(addrROMaddr), 32'd0);
        chk("fs_wren", 32'(wren), 32'd0);
        send(8'h00, w, wn, wo, wa, t);
        chk("fs_hdr_wren", 32'(w), 32'd0);
        chk("fs_no_write", 32'(wren_cnt - base_w), 32'd0);
        send(8'h05, w, wn, wo, wa, t);
        chk("fs_low_wren", 32'(w), 32'd1);
        chk("fs_low_wrd", 32'(wo), 32'h00A);
        chk("fs_low_addr", 32'(wa), 32'd100);

        // ROM counter wrap after 384 writes.
        do_reset(1'b0);
        base_w  = wren_cnt;
        base_fd = fd_cnt;
        for (int g = 0; g < 96; g++) begin
            send(8'h00, w, wn, wo, wa, t);
            for (int k = 0; k < 4; k++) send(8'(g + k), w, wn, wo, wa, t);
        end
        chk("wrap_writes", 32'(wren_cnt - base_w), 32'd384);
        chk("wrap_fd_count", 32'(fd_cnt - base_fd), 32'd1);
        chk("wrap_fd_at", 32'(fd_at - base_w), 32'd384);
        chk("wrap_last_addr", 32'(wa), 32'd483);
        chk("wrap_rc", 32'(addrROMaddr), 32'd0);
        send(8'h00, w, wn, wo, wa, t);
        send(8'h07, w, wn, wo, wa, t);
        chk("wrap_next_addr", 32'(wa), 32'd100);

        // Reset asserted during the WRITE cycle.
        do_reset(1'b0);
        send(8'hFF, w, wn, wo, wa, t);
        @(posedge clk); #1;
        rawData = 8'h12;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
        chk("rw_wren_in_write", 32'(wren), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rw_wren", 32'(wren), 32'd0);
        chk("rw_fdone", 32'(frameDone), 32'd0);
        chk("rw_wrdOut", 32'(wrdOut), 32'd0);
        chk("rw_wrdAddr", 32'(wrdAddr), 32'd0);
        chk("rw_romaddr", 32'(addrROMaddr), 32'd0);
        chk("rw_test", 32'(test), 32'd0);
        reset = 1'b1;

        // NCH=2 configuration.
        do_reset(1'b0);
        send2(8'hA5, w, wo2);
        chk("n2_hdr_wren", 32'(w), 32'd0);
        send2(8'hFF, w, wo2);
        chk("n2_w0_wren", 32'(w), 32'd1);
        chk("n2_w0_wrd", 32'(wo2), 32'h15FE);
        send2(8'h01, w, wo2);
        chk("n2_w1_wren", 32'(w), 32'd1);
        chk("n2_w1_wrd", 32'(wo2), 32'h0A02);

        chk("stray_framedone", 32'(fd_stray), 32'd0);
        chk("double_wren", 32'(dbl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcb_unpacker.md
LCB_UNPACKER -- requirements
Module: lcb_unpacker

Interface
REQ-001 Parameter NCH, default 4: channels per group; legal values 1, 2, 4, 8; HB=8/NCH high bits per channel; sample width SW=8+HB.
REQ-002 Parameter GROUPS, default 3: groups per frame; one group is 1 header byte plus NCH low bytes.
REQ-003 Parameter ROM_DEPTH, default 384: number of address-ROM entries before the wrap.
REQ-004 Parameter ADDR_W, default 9: address-ROM address width.
REQ-005 Parameter DATA_W, default 15: address-ROM data width.
REQ-006 Parameter WADDR_LSB, default 4: lowest ROM-data bit used as the word address.
REQ-007 Parameter WADDR_W, default 10: word-RAM address width.
REQ-008 Parameter OUT_W, default 12: word width; OUT_W >= SW+2.
REQ-009 clk  in  1  sole clock; all logic on rising edge.
REQ-010 reset  in  1  synchronous, active-low reset.
REQ-011 rawData  in  8  received byte, valid while rxValid is high.
REQ-012 rxValid  in  1  level strobe; one byte per low-to-high episode.
REQ-013 frameSync  in  1  one-cycle frame realign pulse.
REQ-014 addrROMaddr  out  ADDR_W  address-ROM read address.
REQ-015 dataROMaddr  in  DATA_W  address-ROM read data, one-cycle read latency.
REQ-016 wrdOut  out  OUT_W  unpacked word to the word RAM.
REQ-017 wrdAddr  out  WADDR_W  word-RAM write address.
REQ-018 wren  out  1  word-RAM write enable.
REQ-019 frameDone  out  1  one-cycle pulse on ROM-counter wrap.
REQ-020 test  out  1  high while the byte counter is in the last group of the frame.

Function
REQ-021 States: IDLE, WRITE, WAIT_LOW. Byte counter bc runs 0..GROUPS*(NCH+1)-1. ROM counter rc runs 0..ROM_DEPTH-1. addrROMaddr = rc, driven from a register.
REQ-022 A byte is accepted only in IDLE with rxValid=1; every accepted byte increments bc, and bc wraps to 0 after its maximum value.
REQ-023 Header byte (bc mod (NCH+1) = 0): high part of channel i <= rawData[8-1-i*HB -: HB], with channel 0 in the MSBs; next state WAIT_LOW; no write.
REQ-024 Low byte k (k = 1..NCH): low 8 bits of channel k-1 <= rawData; wrdOut <= zero-extended {sample, 1'b0}, with bit 0 = 0 and the MSBs = 0; wrdAddr <= dataROMaddr[WADDR_LSB +: WADDR_W]; next state WRITE.
REQ-025 WRITE: wren=1 for exactly this one cycle; rc <= rc+1, or 0 when rc=ROM_DEPTH-1; frameDone=1 in the same cycle as the wrap; next state WAIT_LOW.
REQ-026 WAIT_LOW: stay until rxValid=0, then go to IDLE; rxValid held high never produces a second acceptance.
REQ-027 wren and frameDone are 0 in every cycle other than WRITE.
REQ-028 wrdOut and wrdAddr hold their values from the acceptance edge until the next low-byte acceptance.
REQ-029 Latency: low byte accepted at edge N -> wren high in cycle N+1 -> RAM write at edge N+2.
REQ-030 ROM timing: rc changes only in WRITE, and at least 2 cycles pass before the next acceptance, so dataROMaddr is always settled.
REQ-031 frameSync=1 in any state: bc <= 0, rc <= 0, state <= IDLE, wren <= 0; no byte is accepted in that cycle, and frameSync takes priority over rxValid.
REQ-032 The write that completes a frame (bc wrap) and an rc wrap are independent; each counter wraps only at its own limit.

Reset
REQ-033 reset=0 at a clock edge: state=IDLE, bc=0, rc=0, all channel registers 0, wrdOut=0, wrdAddr=0, wren=0, frameDone=0, addrROMaddr=0.
REQ-034 Reset dominates frameSync and rxValid; if reset occurs mid-group, the partial group is discarded and no write is issued.
REQ-035 After reset is released, a byte is accepted only if rxValid rises from 0; a level already high at release is ignored until it goes low.

Verification
REQ-036 Defaults; header 0xE4, then 0x12, 0x34, 0x56, 0x78 -> wrdOut = 0x624, 0x468, 0x2AC, 0x0F0 on 4 one-cycle wren pulses; rc = 4.
REQ-037 rxValid held high for 10 cycles on a low byte -> exactly one wren pulse; the next byte is accepted only after a low cycle.
REQ-038 384 low bytes -> rc wraps to 0; frameDone pulses once, coincident with the 384th wren; the next addrROMaddr is 0.
REQ-039 frameSync after the header plus 2 low bytes -> the next byte is treated as a header; rc = 0; no write issued.
REQ-040 NCH=2 (HB=4, SW=12, OUT_W=14); header 0xA5, then 0xFF, 0x01 -> wrdOut = 0x15FE, 0x0A02.
REQ-041 reset asserted in the WRITE cycle -> wren = 0 on the following cycle; all outputs match the values in REQ-033.
